if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RV32I pipeline.
- Holds the PC and issues requests to instruction memory.
- Selects the next PC from the EX-stage NPCOp/target information produced by the control decoder.
- Drives the IF/ID pipeline register consumed by ID, where Op/Funct3/Funct7 are decoded.
- Handles load-use stalls, branch/jump redirect flushes and a variable-latency imem handshake.

---
 rtl/if_stage.sv | 196 +++++++++++++++++++
 tb/tb_if_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of a 5-stage RV32I pipeline.
//
// Holds the fetch PC and issues one request at a time to instruction memory.
// The next PC is chosen from the NPCOp/target information of the instruction
// currently in EX. The stage drives the IF/ID pipeline register consumed by
// the decode stage. It also handles load-use stalls, redirect flushes and a
// variable-latency imem handshake.
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   rstn           asynchronous active-low reset
//   stall_i        hazard unit: hold PC and IF/ID (load-use)
//   npc_op_i[2:0]  NPCOp of the EX instruction: 000 +4, 001 branch taken,
//                  010 jal, 100 jalr (priority bit2 > bit1 > bit0)
//   pc_ex_i        PC of the EX instruction
//   imm_ex_i       extended immediate of the EX instruction
//   alu_ex_i       ALU result in EX (jalr target rs1+imm)
//   imem_req_o     fetch request
//   imem_addr_o    fetch address (always equals pc_o)
//   imem_rdata_i   fetched instruction, valid while imem_ready_i=1
//   imem_ready_i   response to the current request (same or later cycle)
//   pc_o           current fetch PC
//   if_id_pc_o     PC of the instruction held in IF/ID
//   if_id_inst_o   instruction held in IF/ID
//   if_id_valid_o  IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall_i,
  input  logic [2:0]  npc_op_i,
  input  logic [31:0] pc_ex_i,
  input  logic [31:0] imm_ex_i,
  input  logic [31:0] alu_ex_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_inst_o,
  output logic        if_id_valid_o
);

  // RUN  : request outstanding for pc_q, results flow into IF/ID.
  // HOLD : a fetched word sits in the skid register while decode is stalled;
  //        no request is issued.
  // KILL : a wrong-path fetch is still in flight; its response is dropped
  //        and fetching resumes at the pending target.
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_KILL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_inst_q, if_id_inst_d;
  logic        if_id_valid_q, if_id_valid_d;

  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;

  // Redirect target. Illegal encodings with several bits set resolve by
  // priority; the low two bits are cleared so the fetch stays word aligned.
  assign redirect = |npc_op_i;

  always_comb begin
    if (npc_op_i[2]) begin
      target_raw = alu_ex_i & ~32'h1;
    end else begin
      target_raw = pc_ex_i + imm_ex_i;
    end
    target = target_raw & 32'hFFFF_FFFC;
  end

  // Next-state and IF/ID update.
  always_comb begin
    // NOTE: every variable gets a hold value before the case statement so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    skid_d        = skid_q;
    pend_d        = pend_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_valid_d = if_id_valid_q;

    unique case (state_q)
      ST_RUN: begin
        if (redirect) begin
          // Flush wins over stall: the younger instruction is squashed.
          if_id_pc_d    = '0;
          if_id_inst_d  = NOP_INST;
          if_id_valid_d = 1'b0;
          if (imem_ready_i) begin
            pc_d = target;
          end else begin
            // Address must stay put until the stale response arrives.
            pend_d  = target;
            state_d = ST_KILL;
          end
        end else if (imem_ready_i) begin
          if (stall_i) begin
            skid_d  = imem_rdata_i;
            state_d = ST_HOLD;
          end else begin
            if_id_pc_d    = pc_q;
            if_id_inst_d  = imem_rdata_i;
            if_id_valid_d = 1'b1;
            pc_d          = pc_q + 32'd4;
          end
        end else if (!stall_i) begin
          if_id_pc_d    = '0;
          if_id_inst_d  = NOP_INST;
          if_id_valid_d = 1'b0;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          skid_d        = '0;
          pc_d          = target;
          if_id_pc_d    = '0;
          if_id_inst_d  = NOP_INST;
          if_id_valid_d = 1'b0;
          state_d       = ST_RUN;
        end else if (!stall_i) begin
          if_id_pc_d    = pc_q;
          if_id_inst_d  = skid_q;
          if_id_valid_d = 1'b1;
          pc_d          = pc_q + 32'd4;
          state_d       = ST_RUN;
        end
      end

      ST_KILL: begin
        // IF/ID was already bubbled on entry; keep it empty until the
        // correct-path fetch completes.
        if_id_pc_d    = '0;
        if_id_inst_d  = NOP_INST;
        if_id_valid_d = 1'b0;
        if (redirect) begin
          pend_d = target;
        end
        if (imem_ready_i) begin
          pc_d    = redirect ? target : pend_q;
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      skid_q        <= '0;
      pend_q        <= '0;
      if_id_pc_q    <= '0;
      if_id_inst_q  <= NOP_INST;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      skid_q        <= skid_d;
      pend_q        <= pend_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  // Request is gated by reset so it drops immediately when rstn asserts.
  assign imem_req_o    = rstn && (state_q != ST_HOLD);
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_inst_o  = if_id_inst_q;
  assign if_id_valid_o = if_id_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
//
// A behavioural model of the fetch stage is stepped with the same inputs the
// DUT sees at each rising edge; DUT outputs are compared against it on every
// falling edge. Directed sequences pin the model with literal expectations,
// then a randomized phase exercises stalls, redirects and imem wait states.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rstn;
  logic        stall_i;
  logic [2:0]  npc_op_i;
  logic [31:0] pc_ex_i;
  logic [31:0] imm_ex_i;
  logic [31:0] alu_ex_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        imem_ready_i;
  logic [31:0] pc_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_inst_o;
  logic        if_id_valid_o;

  int n_checks = 0;
  int n_fail   = 0;

  if_stage dut (
    .clk          (clk),
    .rstn         (rstn),
    .stall_i      (stall_i),
    .npc_op_i     (npc_op_i),
    .pc_ex_i      (pc_ex_i),
    .imm_ex_i     (imm_ex_i),
    .alu_ex_i     (alu_ex_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata_i),
    .imem_ready_i (imem_ready_i),
    .pc_o         (pc_o),
    .if_id_pc_o   (if_id_pc_o),
    .if_id_inst_o (if_id_inst_o),
    .if_id_valid_o(if_id_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Garbage on the data bus whenever ready is low, so a stray capture shows.
  assign imem_rdata_i = imem_ready_i ? mem_word(imem_addr_o) : 32'hDEAD_BEEF;

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  logic [31:0] m_ifid_pc;
  logic [31:0] m_ifid_inst;
  logic        m_ifid_valid;
  bit          m_skid_full;   // fetched word parked while decode stalls
  logic [31:0] m_skid;
  bit          m_killing;     // stale fetch in flight, resume at m_pend
  logic [31:0] m_pend;
  bit          m_in_reset;

  task automatic model_reset();
    m_pc         = 32'h0;
    m_ifid_pc    = 32'h0;
    m_ifid_inst  = NOP;
    m_ifid_valid = 1'b0;
    m_skid_full  = 1'b0;
    m_skid       = 32'h0;
    m_killing    = 1'b0;
    m_pend       = 32'h0;
    m_in_reset   = 1'b1;
  endtask

  task automatic model_bubble();
    m_ifid_pc    = 32'h0;
    m_ifid_inst  = NOP;
    m_ifid_valid = 1'b0;
  endtask

  function automatic logic [31:0] model_target(input logic [2:0] op, input logic [31:0] pex,
                                               input logic [31:0] imm, input logic [31:0] alu);
    logic [31:0] t;
    if (op[2]) t = alu;
    else       t = pex + imm;
    return {t[31:2], 2'b00};
  endfunction

  // Advance the model by one rising edge using the current input values.
  task automatic model_step();
    bit          redir;
    logic [31:0] tgt;
    redir = (npc_op_i != 3'b000);
    tgt   = model_target(npc_op_i, pc_ex_i, imm_ex_i, alu_ex_i);
    if (m_skid_full) begin
      if (redir) begin
        m_skid_full = 1'b0;
        m_pc        = tgt;
        model_bubble();
      end else if (!stall_i) begin
        m_ifid_pc    = m_pc;
        m_ifid_inst  = m_skid;
        m_ifid_valid = 1'b1;
        m_pc         = m_pc + 32'd4;
        m_skid_full  = 1'b0;
      end
    end else if (m_killing) begin
      if (redir) m_pend = tgt;
      model_bubble();
      if (imem_ready_i) begin
        m_pc      = m_pend;
        m_killing = 1'b0;
      end
    end else begin
      if (redir) begin
        model_bubble();
        if (imem_ready_i) m_pc = tgt;
        else begin
          m_pend    = tgt;
          m_killing = 1'b1;
        end
      end else if (imem_ready_i) begin
        if (stall_i) begin
          m_skid      = mem_word(m_pc);
          m_skid_full = 1'b1;
        end else begin
          m_ifid_pc    = m_pc;
          m_ifid_inst  = mem_word(m_pc);
          m_ifid_valid = 1'b1;
          m_pc         = m_pc + 32'd4;
        end
      end else if (!stall_i) begin
        model_bubble();
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("pc_o",          pc_o,                    m_pc);
    check("imem_addr_o",   imem_addr_o,             m_pc);
    check("imem_req_o",    {31'b0, imem_req_o},     {31'b0, !m_in_reset && !m_skid_full});
    check("if_id_pc_o",    if_id_pc_o,              m_ifid_pc);
    check("if_id_inst_o",  if_id_inst_o,            m_ifid_inst);
    check("if_id_valid_o", {31'b0, if_id_valid_o},  {31'b0, m_ifid_valid});
  endtask

  // Drive inputs (called at a falling edge), step model, clock, compare.
  task automatic cycle(input logic st, input logic [2:0] op, input logic [31:0] pex,
                       input logic [31:0] imm, input logic [31:0] alu, input logic rdy);
    stall_i      = st;
    npc_op_i     = op;
    pc_ex_i      = pex;
    imm_ex_i     = imm;
    alu_ex_i     = alu;
    imem_ready_i = rdy;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc_o"},    pc_o,                   32'h0);
    check({tag, "_req"},     {31'b0, imem_req_o},    32'h0);
    check({tag, "_ifid_pc"}, if_id_pc_o,             32'h0);
    check({tag, "_inst"},    if_id_inst_o,           NOP);
    check({tag, "_valid"},   {31'b0, if_id_valid_o}, 32'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn       = 1'b1;
    m_in_reset = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    stall_i = 1'b0; npc_op_i = 3'b000; pc_ex_i = '0; imm_ex_i = '0; alu_ex_i = '0;
    imem_ready_i = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    compare_model();
    check_reset_values("reset");
    rstn       = 1'b1;
    m_in_reset = 1'b0;

    // Sequential fetch, ready tied high: first load on the first edge.
    cycle(0, 3'b000, 0, 0, 0, 1);
    check("seq0_pc",    if_id_pc_o,   32'h0);
    check("seq0_inst",  if_id_inst_o, mem_word(32'h0));
    check("seq0_valid", {31'b0, if_id_valid_o}, 32'h1);
    check("seq0_pc_o",  pc_o,         32'h4);
    cycle(0, 3'b000, 0, 0, 0, 1);
    check("seq1_pc",    if_id_pc_o,   32'h4);
    check("seq1_pc_o",  pc_o,         32'h8);

    // Load-use stall for two cycles at pc 8.
    cycle(1, 3'b000, 0, 0, 0, 1);
    check("stall0_ifid", if_id_pc_o, 32'h4);
    check("stall0_pc_o", pc_o,       32'h8);
    check("stall0_req",  {31'b0, imem_req_o}, 32'h0);
    cycle(1, 3'b000, 0, 0, 0, 1);
    check("stall1_ifid", if_id_pc_o, 32'h4);
    check("stall1_req",  {31'b0, imem_req_o}, 32'h0);
    cycle(0, 3'b000, 0, 0, 0, 1);
    check("rel_pc",    if_id_pc_o,   32'h8);
    check("rel_inst",  if_id_inst_o, mem_word(32'h8));
    check("rel_valid", {31'b0, if_id_valid_o}, 32'h1);
    cycle(0, 3'b000, 0, 0, 0, 1);
    check("rel_next",  if_id_pc_o,   32'hC);

    // Taken branch: 0x10 + 0x20.
    cycle(0, 3'b001, 32'h10, 32'h20, 0, 1);
    check("br_pc_o",  pc_o,         32'h30);
    check("br_inst",  if_id_inst_o, NOP);
    check("br_valid", {31'b0, if_id_valid_o}, 32'h0);
    cycle(0, 3'b000, 0, 0, 0, 1);
    check("br_tgt_pc",   if_id_pc_o,   32'h30);
    check("br_tgt_inst", if_id_inst_o, mem_word(32'h30));

    // jalr clears bit 0, alignment clears bit 1; illegal 011 uses jal path.
    cycle(0, 3'b100, 32'h0, 32'h0, 32'h107, 1);
    check("jalr_pc_o", pc_o, 32'h104);
    cycle(0, 3'b011, 32'h200, 32'h8, 32'h999, 1);
    check("op011_pc_o", pc_o, 32'h208);

    // Redirect during a wait-state fetch at 0x20.
    cycle(0, 3'b001, 32'h0, 32'h20, 0, 1);
    check("to20_pc_o", pc_o, 32'h20);
    cycle(0, 3'b001, 32'h0, 32'h40, 0, 0);
    check("kill0_addr",  imem_addr_o, 32'h20);
    check("kill0_valid", {31'b0, if_id_valid_o}, 32'h0);
    cycle(0, 3'b000, 0, 0, 0, 0);
    check("kill1_addr",  imem_addr_o, 32'h20);
    cycle(0, 3'b000, 0, 0, 0, 0);
    check("kill2_addr",  imem_addr_o, 32'h20);
    check("kill2_valid", {31'b0, if_id_valid_o}, 32'h0);
    cycle(0, 3'b000, 0, 0, 0, 1);
    check("kill_done_addr",  imem_addr_o, 32'h40);
    check("kill_done_valid", {31'b0, if_id_valid_o}, 32'h0);
    cycle(0, 3'b000, 0, 0, 0, 1);
    check("after_kill_pc",   if_id_pc_o,   32'h40);
    check("after_kill_inst", if_id_inst_o, mem_word(32'h40));

    // Reset asserted mid-HOLD.
    cycle(1, 3'b000, 0, 0, 0, 1);
    check("hold_req", {31'b0, imem_req_o}, 32'h0);
    rstn = 1'b0;
    model_reset();
    #1;
    compare_model();
    check_reset_values("rst_hold");
    release_reset();
    cycle(0, 3'b000, 0, 0, 0, 1);
    check("rst_hold_first_pc",    if_id_pc_o, 32'h0);
    check("rst_hold_first_valid", {31'b0, if_id_valid_o}, 32'h1);

    // Reset asserted mid-KILL.
    cycle(0, 3'b010, 32'h100, 32'h40, 0, 0);
    rstn = 1'b0;
    model_reset();
    #1;
    compare_model();
    check_reset_values("rst_kill");
    release_reset();
    cycle(0, 3'b000, 0, 0, 0, 1);
    check("rst_kill_first_pc", if_id_pc_o, 32'h0);
    check("rst_kill_pc_o",     pc_o,       32'h4);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      logic       st;
      logic [2:0] op;
      logic       rdy;
      st  = ($urandom_range(0, 3) == 0);
      op  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      rdy = ($urandom_range(0, 2) != 0);
      cycle(st, op, $urandom, $urandom, $urandom, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
